// File: rtl/micro_seq_pkg.sv
// Shared definitions for the micro-sequencer: jump-mode field codes and run-state encoding.
package micro_seq_pkg;

    localparam logic [2:0] JMP_NEXT = 3'b000;
    localparam logic [2:0] JMP_DISP = 3'b001;
    localparam logic [2:0] JMP_ZBR  = 3'b010;
    localparam logic [2:0] JMP_CALL = 3'b011;
    localparam logic [2:0] JMP_RET  = 3'b100;
    localparam logic [2:0] JMP_HALT = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_HALT  = 2'd2,
        S_ERROR = 2'd3
    } seq_state_t;

endpackage

// File: rtl/micro_sequencer_if.sv
// Control-store / datapath side of the micro-sequencer, bundled as one interface.
interface micro_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic              stall;
    logic [ADDR_W-1:0] mir_next;
    logic [2:0]        mir_jmp;
    logic [ADDR_W-1:0] ir;
    logic              z;
    logic [ADDR_W-1:0] upc;
    logic              busy;
    logic              halted;
    logic              stack_err;

    // master: control store, IR and ALU flags feeding the sequencer
    modport master (
        output start, stall, mir_next, mir_jmp, ir, z,
        input  upc, busy, halted, stack_err
    );

    modport slave (
        input  start, stall, mir_next, mir_jmp, ir, z,
        output upc, busy, halted, stack_err
    );
endinterface

// File: rtl/micro_ret_stack.sv
// Micro-return address stack; callers guarantee push and pop are never asserted together.
module micro_ret_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int SPW = $clog2(DEPTH + 1);
    localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]   mem [DEPTH];
    logic [SPW-1:0] sp;
    logic [SPW-1:0] top_idx;

    assign full    = (sp == SPW'(DEPTH));
    assign empty   = (sp == '0);
    assign top_idx = sp - SPW'(1);
    assign dout    = mem[top_idx[IW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp <= '0;
        end else if (flush) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + SPW'(1);
        end else if (pop && !empty) begin
            sp <= sp - SPW'(1);
        end
    end

    // Entries are only meaningful below sp, so storage needs no reset.
    always_ff @(posedge clk) begin
        if (push && !full && !flush) begin
            mem[sp[IW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/micro_sequencer.sv
// Next-microaddress generator and run controller for the microprogrammed control store.
module micro_sequencer
    import micro_seq_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4,
    parameter int FETCH_ADDR  = 0,
    parameter int Z_SET_ADDR  = 21,
    parameter int Z_CLR_ADDR  = 40
) (
    input  logic              clk,
    input  logic              rst,
    micro_sequencer_if.slave  bus
);
    seq_state_t        state_q, state_d;
    logic [ADDR_W-1:0] upc_q, upc_d;
    logic              err_q, err_d;
    logic              push, pop, flush;
    logic              stk_full, stk_empty;
    logic [ADDR_W-1:0] stk_dout;
    logic [ADDR_W-1:0] ret_addr;

    // Natural ADDR_W-bit wrap makes the return address of 2^ADDR_W-1 equal 0.
    assign ret_addr = upc_q + ADDR_W'(1);

    micro_ret_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (ADDR_W)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (ret_addr),
        .dout  (stk_dout),
        .full  (stk_full),
        .empty (stk_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            upc_q   <= ADDR_W'(FETCH_ADDR);
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            upc_q   <= upc_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        upc_d   = upc_q;
        err_d   = err_q;
        push    = 1'b0;
        pop     = 1'b0;
        flush   = 1'b0;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    upc_d   = ADDR_W'(FETCH_ADDR);
                    flush   = 1'b1;
                end
            end
            S_RUN: begin
                // Stall outranks every decode path, including HALT and error checks.
                if (!bus.stall) begin
                    case (bus.mir_jmp)
                        JMP_NEXT: upc_d = bus.mir_next;
                        JMP_DISP: upc_d = bus.ir;
                        JMP_ZBR:  upc_d = bus.z ? ADDR_W'(Z_SET_ADDR) : ADDR_W'(Z_CLR_ADDR);
                        JMP_CALL: begin
                            if (stk_full) begin
                                state_d = S_ERROR;
                                err_d   = 1'b1;
                            end else begin
                                push  = 1'b1;
                                upc_d = bus.mir_next;
                            end
                        end
                        JMP_RET: begin
                            if (stk_empty) begin
                                state_d = S_ERROR;
                                err_d   = 1'b1;
                            end else begin
                                pop   = 1'b1;
                                upc_d = stk_dout;
                            end
                        end
                        JMP_HALT: state_d = S_HALT;
                        default: begin
                            state_d = S_ERROR;
                            err_d   = 1'b1;
                        end
                    endcase
                end
            end
            S_ERROR: err_d = 1'b1;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.upc       = upc_q;
    assign bus.busy      = (state_q == S_RUN);
    assign bus.halted    = (state_q == S_HALT);
    assign bus.stack_err = err_q;

endmodule
